// File: rtl/fw_interface_logger_if.sv
// Output beat stream of the firmware event logger: one header beat per message,
// followed by its string characters, under a valid/ready handshake.
interface fw_interface_logger_if #(
    parameter int CHAN_W = 2
);
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic [CHAN_W-1:0] out_chan;
    logic [31:0]       out_code;
    logic [7:0]        out_char;

    modport master (
        output out_valid, out_first, out_last, out_chan, out_code, out_char,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_first, out_last, out_chan, out_code, out_char,
        output out_ready
    );
endinterface

// File: rtl/fw_interface_logger.sv
// Firmware event logger: accepts per-channel event strobes with an attached
// string from a double-buffered character store, and streams them out as messages.
module fw_interface_logger #(
    parameter int  CHANNELS  = 3,
    parameter int  STR_DEPTH = 64,
    parameter int  CNT_W     = 16,
    localparam int AW        = $clog2(STR_DEPTH),
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [CHANNELS-1:0]       new_event,
    input  logic [32*CHANNELS-1:0]    event_reg,
    input  logic [AW:0]               str_len,
    input  logic [AW-1:0]             index,
    input  logic [7:0]                data,
    input  logic                      write_mem,
    fw_interface_logger_if.master     out_if,
    output logic                      full,
    output logic [CNT_W*CHANNELS-1:0] chan_count,
    output logic [CNT_W-1:0]          drop_count
);

    localparam int              NW        = $clog2(CHANNELS + 1);
    localparam int              DW        = CNT_W + NW;
    localparam logic [AW:0]     DEPTH_LEN = (AW + 1)'(STR_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] STR  = 2'd2;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [31:0]   code;
        logic [AW:0]   len;
    } msg_t;

    logic [7:0]       bank0 [STR_DEPTH];
    logic [7:0]       bank1 [STR_DEPTH];

    // Queue slot i always owns string bank i, so wr_sel doubles as the write slot.
    msg_t             q [2];
    msg_t             head;
    logic             wr_sel;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [AW-1:0]    ptr;

    logic [CNT_W-1:0] chan_cnt [CHANNELS];
    logic [CNT_W-1:0] drop_cnt;
    logic [DW-1:0]    drop_sum;

    logic [CW-1:0]    sel_chan;
    logic [31:0]      sel_code;
    logic [NW-1:0]    n_set;
    logic [NW-1:0]    n_drop;
    logic             found;
    logic             accept;
    logic [AW:0]      len_in;

    logic             valid;
    logic             first;
    logic             last;
    logic [CW-1:0]    o_chan;
    logic [31:0]      o_code;
    logic [7:0]       o_char;
    logic             hs;
    logic             pop;
    logic             more;

    assign full = (count == 2'd2);
    assign head = q[rd_ptr];

    // NOTE: every variable written in a combinational block gets a default first,
    // otherwise paths that skip an assignment infer a latch.
    always_comb begin
        sel_chan = '0;
        sel_code = '0;
        n_set    = '0;
        found    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (new_event[c]) begin
                if (!found) begin
                    sel_chan = CW'(c);
                    sel_code = event_reg[32*c +: 32];
                end
                found = 1'b1;
                n_set = n_set + NW'(1);
            end
        end
        accept = found && !full;
        n_drop = accept ? n_set - NW'(1) : n_set;
    end

    assign len_in   = (str_len > DEPTH_LEN) ? DEPTH_LEN : str_len;
    assign drop_sum = {{NW{1'b0}}, drop_cnt} + DW'(n_drop);

    // Outputs are decoded from registered state, so reset silences them at once.
    always_comb begin
        valid  = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
        o_chan = '0;
        o_code = '0;
        o_char = '0;
        case (state)
            HDR: begin
                valid  = 1'b1;
                first  = 1'b1;
                last   = (head.len == '0);
                o_chan = head.chan;
                o_code = head.code;
            end
            STR: begin
                valid  = 1'b1;
                last   = ({1'b0, ptr} == head.len - (AW + 1)'(1));
                o_chan = head.chan;
                o_code = head.code;
                o_char = rd_ptr ? bank1[ptr] : bank0[ptr];
            end
            default: ;
        endcase
    end

    assign out_if.out_valid = valid;
    assign out_if.out_first = first;
    assign out_if.out_last  = last;
    assign out_if.out_chan  = o_chan;
    assign out_if.out_code  = o_code;
    assign out_if.out_char  = o_char;

    assign hs   = valid && out_if.out_ready;
    assign pop  = hs && last;
    assign more = (count == 2'd2) || accept;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (count != 2'd0 || accept) state_next = HDR;
            HDR: begin
                if (hs) begin
                    if (head.len != '0) state_next = STR;
                    else                state_next = more ? HDR : IDLE;
                end
            end
            STR:     if (pop) state_next = more ? HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            ptr      <= '0;
            wr_sel   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            q[0]     <= '0;
            q[1]     <= '0;
            drop_cnt <= '0;
            for (int c = 0; c < CHANNELS; c++) chan_cnt[c] <= '0;
        end else begin
            state <= state_next;
            if (state == STR && hs) ptr <= last ? '0 : ptr + AW'(1);
            if (accept) begin
                q[wr_sel] <= '{chan: sel_chan, code: sel_code, len: len_in};
                wr_sel    <= ~wr_sel;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
            drop_cnt <= (drop_sum > DW'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
            for (int c = 0; c < CHANNELS; c++) begin
                if (accept && sel_chan == CW'(c) && chan_cnt[c] != CNT_MAX)
                    chan_cnt[c] <= chan_cnt[c] + CNT_W'(1);
            end
        end
    end

    // NOTE: the string banks are plain storage with no reset, which keeps them
    // mappable to RAM; a bank is only read after it has been written.
    always_ff @(posedge wb_clk_i) begin
        if (write_mem && !full) begin
            if (wr_sel) bank1[index] <= data;
            else        bank0[index] <= data;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
        assign chan_count[g*CNT_W +: CNT_W] = chan_cnt[g];
    end

    assign drop_count = drop_cnt;

endmodule
